// File: rtl/spi_reg_access_ctrl.sv
// Register-access controller feeding the spi_driver user interface.
// Each request becomes a 2-byte frame; one response per request, with a timeout flag.
module spi_reg_access_ctrl #(
  parameter int P_WRITE_DATA_WIDTH = 8,
  parameter int P_READ_DATA_WIDTH  = 8,
  parameter int P_TIMEOUT          = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic                          i_req_rw,
  input  logic [6:0]                    i_req_addr,
  input  logic [7:0]                    i_req_wdata,
  output logic                          o_rsp_valid,
  output logic [P_READ_DATA_WIDTH-1:0]  o_rsp_rdata,
  output logic                          o_rsp_err,
  output logic [7:0]                    o_err_cnt,
  output logic [P_WRITE_DATA_WIDTH-1:0] o_user_write_data,
  output logic                          o_user_write_valid,
  input  logic                          i_user_write_ready,
  input  logic [P_READ_DATA_WIDTH-1:0]  i_user_read_data,
  input  logic                          i_user_read_valid
);

  localparam int TIMER_W = $clog2(P_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(P_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND0,
    WAIT0,
    SEND1,
    WAIT1,
    RESP
  } state_t;

  state_t                          state;
  logic [P_WRITE_DATA_WIDTH-1:0]   byte1;
  logic                            err;
  logic [TIMER_W-1:0]              timer;

  // Byte1 is resolved at acceptance so the request fields need not be kept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= IDLE;
      o_req_ready        <= 1'b1;
      o_user_write_valid <= 1'b0;
      o_user_write_data  <= '0;
      o_rsp_valid        <= 1'b0;
      o_rsp_err          <= 1'b0;
      o_rsp_rdata        <= '0;
      o_err_cnt          <= 8'h00;
      byte1              <= '0;
      err                <= 1'b0;
      timer              <= '0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            o_user_write_data  <= {i_req_rw, i_req_addr};
            byte1              <= i_req_rw ? 8'h00 : i_req_wdata;
            o_user_write_valid <= 1'b1;
            o_req_ready        <= 1'b0;
            timer              <= '0;
            state              <= SEND0;
          end
        end
        SEND0: begin
          if (i_user_write_ready) begin
            o_user_write_valid <= 1'b0;
            timer              <= '0;
            state              <= WAIT0;
          end
        end
        WAIT0: begin
          if (i_user_read_valid) begin
            o_user_write_data  <= byte1;
            o_user_write_valid <= 1'b1;
            state              <= SEND1;
          end else if (timer == TIMER_LAST) begin
            err         <= 1'b1;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            state       <= RESP;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        SEND1: begin
          if (i_user_write_ready) begin
            o_user_write_valid <= 1'b0;
            timer              <= '0;
            state              <= WAIT1;
          end
        end
        WAIT1: begin
          if (i_user_read_valid) begin
            o_rsp_rdata <= i_user_read_data;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= err;
            state       <= RESP;
          end else if (timer == TIMER_LAST) begin
            err         <= 1'b1;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            state       <= RESP;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        RESP: begin
          // Error counter sticks at its maximum instead of wrapping.
          if (err && (o_err_cnt != 8'hFF)) begin
            o_err_cnt <= o_err_cnt + 8'h01;
          end
          err         <= 1'b0;
          o_req_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          o_user_write_valid <= 1'b0;
          o_req_ready        <= 1'b1;
          err                <= 1'b0;
          state              <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_access_ctrl.sv
// Directed bench for spi_reg_access_ctrl; the bench plays the spi_driver side by hand.
module tb_spi_reg_access_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_req_valid;
  logic       o_req_ready;
  logic       i_req_rw;
  logic [6:0] i_req_addr;
  logic [7:0] i_req_wdata;
  logic       o_rsp_valid;
  logic [7:0] o_rsp_rdata;
  logic       o_rsp_err;
  logic [7:0] o_err_cnt;
  logic [7:0] o_user_write_data;
  logic       o_user_write_valid;
  logic       i_user_write_ready;
  logic [7:0] i_user_read_data;
  logic       i_user_read_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 i_clk = ~i_clk;

  spi_reg_access_ctrl #(
    .P_WRITE_DATA_WIDTH(8),
    .P_READ_DATA_WIDTH (8),
    .P_TIMEOUT         (16)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_req_valid       (i_req_valid),
    .o_req_ready       (o_req_ready),
    .i_req_rw          (i_req_rw),
    .i_req_addr        (i_req_addr),
    .i_req_wdata       (i_req_wdata),
    .o_rsp_valid       (o_rsp_valid),
    .o_rsp_rdata       (o_rsp_rdata),
    .o_rsp_err         (o_rsp_err),
    .o_err_cnt         (o_err_cnt),
    .o_user_write_data (o_user_write_data),
    .o_user_write_valid(o_user_write_valid),
    .i_user_write_ready(i_user_write_ready),
    .i_user_read_data  (i_user_read_data),
    .i_user_read_valid (i_user_read_valid)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present a request in an IDLE cycle and step past the accepting edge.
  task automatic applyStimulus(input logic rw, input logic [6:0] addr, input logic [7:0] wdata, input logic hold);
    i_req_valid = 1'b1;
    i_req_rw    = rw;
    i_req_addr  = addr;
    i_req_wdata = wdata;
    checkOutput("req_ready_idle", 8'(o_req_ready), 8'h01);
    @(negedge i_clk);
    if (!hold) i_req_valid = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] exp_byte, input int stall);
    i_user_write_ready = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      checkOutput("stall_wr_valid", 8'(o_user_write_valid), 8'h01);
      checkOutput("stall_wr_data", o_user_write_data, exp_byte);
      @(negedge i_clk);
    end
    i_user_write_ready = 1'b1;
    checkOutput("wr_valid", 8'(o_user_write_valid), 8'h01);
    checkOutput("wr_data", o_user_write_data, exp_byte);
    checkOutput("req_ready_busy", 8'(o_req_ready), 8'h00);
    @(negedge i_clk);
    checkOutput("wr_valid_after_hs", 8'(o_user_write_valid), 8'h00);
  endtask

  task automatic returnByte(input logic [7:0] data);
    i_user_read_valid = 1'b1;
    i_user_read_data  = data;
    @(negedge i_clk);
    i_user_read_valid = 1'b0;
    i_user_read_data  = 8'hEE;
  endtask

  task automatic checkResp(input logic [7:0] exp_rdata, input logic exp_err);
    checkOutput("rsp_valid", 8'(o_rsp_valid), 8'h01);
    checkOutput("rsp_err", 8'(o_rsp_err), 8'(exp_err));
    checkOutput("rsp_rdata", o_rsp_rdata, exp_rdata);
    checkOutput("req_ready_resp", 8'(o_req_ready), 8'h00);
    @(negedge i_clk);
    checkOutput("rsp_valid_pulse", 8'(o_rsp_valid), 8'h00);
    checkOutput("req_ready_back", 8'(o_req_ready), 8'h01);
  endtask

  task automatic frameBody(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] r0, input logic [7:0] r1, input int stall);
    sendByte(b0, stall);
    returnByte(r0);
    sendByte(b1, 0);
    returnByte(r1);
    checkResp(r1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rst              = 1'b1;
    i_req_valid        = 1'b0;
    i_req_rw           = 1'b0;
    i_req_addr         = 7'h00;
    i_req_wdata        = 8'h00;
    i_user_write_ready = 1'b1;
    i_user_read_data   = 8'h00;
    i_user_read_valid  = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    checkOutput("rst_req_ready", 8'(o_req_ready), 8'h01);
    checkOutput("rst_wr_valid", 8'(o_user_write_valid), 8'h00);
    checkOutput("rst_rsp_valid", 8'(o_rsp_valid), 8'h00);
    checkOutput("rst_rsp_err", 8'(o_rsp_err), 8'h00);
    checkOutput("rst_rdata", o_rsp_rdata, 8'h00);
    checkOutput("rst_err_cnt", o_err_cnt, 8'h00);
    checkOutput("rst_wr_data", o_user_write_data, 8'h00);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Plain write, driver ready immediately.
    applyStimulus(1'b0, 7'h05, 8'h12, 1'b0);
    frameBody(8'h05, 8'h12, 8'h3C, 8'h5A, 0);

    // Read of the top address; wdata must not leak into byte1.
    applyStimulus(1'b1, 7'h7F, 8'hC3, 1'b0);
    frameBody(8'hFF, 8'h00, 8'h3C, 8'hA5, 0);

    // Driver stalls byte0 for 10 cycles; no timeout may fire.
    applyStimulus(1'b0, 7'h05, 8'h12, 1'b0);
    frameBody(8'h05, 8'h12, 8'h01, 8'h6E, 10);
    checkOutput("stall_err_cnt", o_err_cnt, 8'h00);

    // No byte returned after byte0: error response 16 cycles after the handshake.
    applyStimulus(1'b0, 7'h05, 8'h12, 1'b0);
    sendByte(8'h05, 0);
    for (int k = 1; k < 16; k++) begin
      @(negedge i_clk);
      checkOutput("to_early_rsp", 8'(o_rsp_valid), 8'h00);
      checkOutput("to_no_byte1", 8'(o_user_write_valid), 8'h00);
    end
    @(negedge i_clk);
    checkOutput("to_rsp_valid", 8'(o_rsp_valid), 8'h01);
    checkOutput("to_rsp_err", 8'(o_rsp_err), 8'h01);
    checkOutput("to_rdata_kept", o_rsp_rdata, 8'h6E);
    checkOutput("to_no_byte1_resp", 8'(o_user_write_valid), 8'h00);
    @(negedge i_clk);
    checkOutput("to_err_cnt", o_err_cnt, 8'h01);
    checkOutput("to_req_ready", 8'(o_req_ready), 8'h01);
    checkOutput("to_rsp_done", 8'(o_rsp_valid), 8'h00);
    checkOutput("to_err_cleared", 8'(o_rsp_err), 8'h00);

    // Reset pulse while waiting for byte1's return.
    applyStimulus(1'b0, 7'h22, 8'h44, 1'b0);
    sendByte(8'h22, 0);
    returnByte(8'h10);
    sendByte(8'h44, 0);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    checkOutput("mid_rst_ready", 8'(o_req_ready), 8'h01);
    checkOutput("mid_rst_wr_valid", 8'(o_user_write_valid), 8'h00);
    checkOutput("mid_rst_rsp", 8'(o_rsp_valid), 8'h00);
    checkOutput("mid_rst_err_cnt", o_err_cnt, 8'h00);
    checkOutput("mid_rst_rdata", o_rsp_rdata, 8'h00);
    returnByte(8'h99);
    checkOutput("idle_rd_ignored", 8'(o_rsp_valid), 8'h00);
    checkOutput("idle_rd_no_send", 8'(o_user_write_valid), 8'h00);
    checkOutput("idle_rd_ready", 8'(o_req_ready), 8'h01);

    // Three requests back to back with valid held high.
    applyStimulus(1'b0, 7'h01, 8'hA1, 1'b1);
    i_req_rw = 1'b1; i_req_addr = 7'h02; i_req_wdata = 8'h00;
    frameBody(8'h01, 8'hA1, 8'h00, 8'h11, 0);
    applyStimulus(1'b1, 7'h02, 8'h00, 1'b1);
    i_req_rw = 1'b0; i_req_addr = 7'h03; i_req_wdata = 8'hB3;
    frameBody(8'h82, 8'h00, 8'h00, 8'h22, 0);
    applyStimulus(1'b0, 7'h03, 8'hB3, 1'b0);
    frameBody(8'h03, 8'hB3, 8'h00, 8'h33, 0);
    @(negedge i_clk);
    checkOutput("b2b_no_extra_rsp", 8'(o_rsp_valid), 8'h00);
    checkOutput("b2b_idle_ready", 8'(o_req_ready), 8'h01);
    checkOutput("b2b_err_cnt", o_err_cnt, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_reg_access_ctrl.md
# spi_reg_access_ctrl

- Register-access controller that sits directly upstream of `spi_driver` and drives its user write/read interface.
- Accepts one register request at a time (read or write, 7-bit address, 8-bit data).
- Serialises each request into a fixed 2-byte SPI frame and collects the full-duplex bytes returned by the driver.
- Returns a single response per request with read data and a timeout error flag; fills the currently unused user side of the SPI top level.

## Interface
Parameters:
- P_WRITE_DATA_WIDTH, 8, byte width toward `spi_driver`; only 8 is supported.
- P_READ_DATA_WIDTH, 8, byte width from `spi_driver`; only 8 is supported.
- P_TIMEOUT, 1024, cycles to wait for a returned byte before aborting; must be ≥ 2.

Ports:
- i_clk  in  1  system clock; the same 100 MHz domain as `spi_driver`.
- i_rst  in  1  reset; synchronous, active-high.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when valid & ready.
- i_req_rw  in  1  1 = read, 0 = write.
- i_req_addr  in  7  register address.
- i_req_wdata  in  8  write data; ignored for reads.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  8  byte received during frame byte 1.
- o_rsp_err  out  1  timeout flag; qualified by o_rsp_valid.
- o_err_cnt  out  8  saturating timeout counter.
- o_user_write_data  out  8  byte to `spi_driver`.
- o_user_write_valid  out  1  byte valid.
- i_user_write_ready  in  1  driver accepts the byte when valid & ready.
- i_user_read_data  in  8  byte received by the driver.
- i_user_read_valid  in  1  one-cycle pulse, once per transferred byte.

## Operation
Frame layout:
- byte0 = {rw, addr[6:0]}.
- byte1 = wdata for a write, 8'h00 dummy for a read.

FSM states: IDLE, SEND0, WAIT0, SEND1, WAIT1, RESP.
- IDLE:
  - o_req_ready = 1.
  - On i_req_valid: latch rw, addr and wdata, clear the timer, go to SEND0.
- SEND0:
  - o_user_write_valid = 1, o_user_write_data = byte0, both held stable until i_user_write_ready.
  - On handshake: clear the timer, go to WAIT0.
- WAIT0:
  - On i_user_read_valid: discard the data, go to SEND1.
  - Else if timer == P_TIMEOUT-1: set err, go to RESP.
- SEND1: same as SEND0 with byte1; on handshake go to WAIT1.
- WAIT1:
  - On i_user_read_valid: capture i_user_read_data into o_rsp_rdata, go to RESP.
  - Timeout handling is identical to WAIT0.
- RESP:
  - o_rsp_valid = 1 for exactly one cycle.
  - o_rsp_err = err; if err, o_err_cnt increments, saturating at 8'hFF.
  - Next state IDLE; err clears on the return to IDLE.

Other rules:
- The timer counts only in WAIT0 and WAIT1; SEND states wait indefinitely for ready.
- i_user_read_valid outside WAIT0/WAIT1 is ignored.
- Write requests also report the received byte in o_rsp_rdata; the requester may ignore it.
- On timeout, o_rsp_rdata keeps its previous value.
- A request presented while not in IDLE is not accepted (o_req_ready = 0); the requester holds it.
- Reset mid-frame:
  - FSM goes to IDLE and o_user_write_valid drops on the next edge.
  - No response is generated.
  - o_err_cnt clears.

## Timing
Reset values:
- State: IDLE.
- o_req_ready: 1.
- o_rsp_valid, o_rsp_err: 0.
- o_rsp_rdata, o_err_cnt, o_user_write_data: 8'h00.
- o_user_write_valid: 0.

Output timing:
- o_req_ready and o_user_write_valid are decoded from state and registered fields; no combinational path from any input.

Cycle-level behaviour:
- Request accepted at edge N → o_user_write_valid high from cycle N+1.
- A read_valid seen in WAIT0 at edge M → byte1 valid from cycle M+1.
- A read_valid seen in WAIT1 at edge K → o_rsp_valid in cycle K+1 and o_req_ready high in cycle K+2.
- Minimum controller overhead is 4 cycles beyond driver latency.
- Timeout:
  - Write handshake at edge T → timer reaches P_TIMEOUT-1 at edge T+P_TIMEOUT-1.
  - o_rsp_valid with err in the following cycle.
- Back-to-back: the next request can be accepted the cycle after RESP.

## Test plan
- Write addr 7'h05, wdata 8'h12, driver ready immediately → bytes 8'h05 then 8'h12 sent; one o_rsp_valid pulse with err = 0.
- Read addr 7'h7F, MISO model returns 8'h3C then 8'hA5 → bytes 8'hFF, 8'h00 sent; o_rsp_rdata = 8'hA5, err = 0.
- i_user_write_ready held low 10 cycles during SEND0 → data 8'h05 and valid stable for all 10 cycles; single handshake; no timeout.
- P_TIMEOUT = 16, no read_valid after byte0 → o_rsp_valid with err = 1 exactly 16 cycles after the handshake; o_err_cnt = 1; byte1 never sent.
- i_rst asserted for one cycle in WAIT1 → IDLE next cycle; o_req_ready = 1; no o_rsp_valid; o_err_cnt = 0.
- Three back-to-back requests with i_req_valid held high → exactly three responses in order; o_req_ready high only in IDLE cycles.
